// File: rtl/clk_div_prog_if.sv
// Control and status bundle of the programmable clock divider.
// The master side drives enable and configuration, the slave side is the divider.
interface clk_div_prog_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic             div_load;
    logic [CNT_W-1:0] div_val;
    logic [CNT_W-1:0] pulse_val;
    logic [CNT_W-1:0] counter;
    logic             clk_div;
    logic             div_tick;
    logic             imp;
    logic             div_busy;
    logic             cfg_err;

    modport master (
        output en, div_load, div_val, pulse_val,
        input  counter, clk_div, div_tick, imp, div_busy, cfg_err
    );

    modport slave (
        input  en, div_load, div_val, pulse_val,
        output counter, clk_div, div_tick, imp, div_busy, cfg_err
    );
endinterface

// File: rtl/clk_div_prog.sv
// Programmable clock divider with a periodic pulse generator.
// A new configuration is staged as pending and only becomes active on a
// divide-counter wrap, so clk_div never produces a shortened (runt) phase.
module clk_div_prog #(
    parameter int CNT_W     = 8,
    parameter int RST_DIV   = 6,
    parameter int RST_PULSE = 5
) (
    input  logic          clk,
    input  logic          reset,
    clk_div_prog_if.slave bus
);
    localparam logic [CNT_W-1:0] ZERO        = '0;
    localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO         = CNT_W'(2);
    localparam logic [CNT_W-1:0] RST_DIV_V   = CNT_W'(RST_DIV);
    localparam logic [CNT_W-1:0] RST_PULSE_V = CNT_W'(RST_PULSE);

    logic [CNT_W-1:0] counter_q;
    logic [CNT_W-1:0] counter2_q;
    logic [CNT_W-1:0] div_cur;
    logic [CNT_W-1:0] pulse_cur;
    logic [CNT_W-1:0] div_nxt;
    logic [CNT_W-1:0] pulse_nxt;
    logic             busy_q;
    logic             err_q;

    logic [CNT_W-1:0] div_last;
    logic [CNT_W-1:0] pulse_last;
    logic             div_wrap;
    logic             pulse_wrap;
    logic             tick;
    logic             apply;
    logic             load_take;
    logic             load_ok;

    // Active ratios are always >= 1, so the "last count" values never underflow.
    assign div_last   = div_cur - ONE;
    assign pulse_last = pulse_cur - ONE;
    assign div_wrap   = (counter_q == div_last);
    assign pulse_wrap = (counter2_q == pulse_last);
    assign tick       = bus.en & div_wrap;
    assign apply      = busy_q & tick;
    assign load_take  = bus.div_load & ~busy_q;
    assign load_ok    = (bus.div_val >= TWO) && (bus.pulse_val != ZERO);

    // Divide and pulse counters: restart together when a pending config is applied.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            counter_q  <= ZERO;
            counter2_q <= ZERO;
        end else if (apply) begin
            counter_q  <= ZERO;
            counter2_q <= ZERO;
        end else if (bus.en) begin
            counter_q  <= div_wrap   ? ZERO : counter_q + ONE;
            counter2_q <= pulse_wrap ? ZERO : counter2_q + ONE;
        end
    end

    // Active configuration: swapped in only at a divide-counter wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cur   <= RST_DIV_V;
            pulse_cur <= RST_PULSE_V;
        end else if (apply) begin
            div_cur   <= div_nxt;
            pulse_cur <= pulse_nxt;
        end
    end

    // Pending configuration, busy and sticky error; loads are ignored while busy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_nxt   <= RST_DIV_V;
            pulse_nxt <= RST_PULSE_V;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else if (apply) begin
            busy_q <= 1'b0;
        end else if (load_take && load_ok) begin
            div_nxt   <= bus.div_val;
            pulse_nxt <= bus.pulse_val;
            busy_q    <= 1'b1;
            err_q     <= 1'b0;
        end else if (load_take) begin
            err_q <= 1'b1;
        end
    end

    assign bus.counter  = counter_q;
    assign bus.clk_div  = (counter_q >= (div_cur >> 1));
    assign bus.div_tick = tick;
    assign bus.imp      = bus.en & pulse_wrap;
    assign bus.div_busy = busy_q;
    assign bus.cfg_err  = err_q;
endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: the driver predicts each cycle's outputs
// from a behavioural model and queues them; the monitor pops and compares.
module tb_clk_div_prog;
    logic clk;
    logic reset;

    clk_div_prog_if #(.CNT_W(8)) bus ();

    clk_div_prog #(.CNT_W(8), .RST_DIV(6), .RST_PULSE(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int counter;
        bit clk_div;
        bit tick;
        bit imp;
        bit busy;
        bit err;
    } exp_t;

    exp_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural reference state
    int m_cnt, m_cnt2, m_div, m_pulse, m_ndiv, m_npulse;
    bit m_busy, m_err;

    // Observation window counters
    bit win = 0;
    int win_ticks = 0;
    int win_imps  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_cnt = 0; m_cnt2 = 0;
        m_div = 6; m_pulse = 5; m_ndiv = 6; m_npulse = 5;
        m_busy = 0; m_err = 0;
    endtask

    // Drive one cycle, queue the expected outputs, advance the model.
    task automatic step(input bit e, input bit ld, input int dv, input int pv);
        exp_t x;
        bit tk;
        bit b0;
        @(negedge clk);
        bus.en        = e;
        bus.div_load  = ld;
        bus.div_val   = 8'(dv);
        bus.pulse_val = 8'(pv);
        tk = e && (m_cnt == m_div - 1);
        x.counter = m_cnt;
        x.clk_div = (m_cnt >= m_div / 2);
        x.tick    = tk;
        x.imp     = e && (m_cnt2 == m_pulse - 1);
        x.busy    = m_busy;
        x.err     = m_err;
        sb.push_back(x);
        b0 = m_busy;
        if (b0 && tk) begin
            m_div = m_ndiv; m_pulse = m_npulse;
            m_cnt = 0; m_cnt2 = 0; m_busy = 0;
        end else if (e) begin
            m_cnt  = (m_cnt + 1) % m_div;
            m_cnt2 = (m_cnt2 + 1) % m_pulse;
        end
        if (ld && !b0) begin
            if (dv >= 2 && pv >= 1) begin
                m_ndiv = dv; m_npulse = pv; m_busy = 1; m_err = 0;
            end else begin
                m_err = 1;
            end
        end
    endtask

    task automatic run(input int n, input bit e);
        for (int i = 0; i < n; i++) step(e, 1'b0, 0, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_counter"}, int'(bus.counter), 0);
        check({tag, "_clk_div"}, int'(bus.clk_div), 0);
        check({tag, "_tick"},    int'(bus.div_tick), 0);
        check({tag, "_imp"},     int'(bus.imp), 0);
        check({tag, "_busy"},    int'(bus.div_busy), 0);
        check({tag, "_err"},     int'(bus.cfg_err), 0);
    endtask

    // Reset asserted between clock edges, held for two cycles.
    task automatic async_reset();
        @(negedge clk);
        bus.en = 1'b0;
        bus.div_load = 1'b0;
        #2 reset = 1'b0;
        #1 check_reset_outputs("async_rst");
        m_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Monitor: sample just before each rising edge and compare to the queue head.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            #3;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                check("counter",  int'(bus.counter),  x.counter);
                check("clk_div",  int'(bus.clk_div),  int'(x.clk_div));
                check("div_tick", int'(bus.div_tick), int'(x.tick));
                check("imp",      int'(bus.imp),      int'(x.imp));
                check("div_busy", int'(bus.div_busy), int'(x.busy));
                check("cfg_err",  int'(bus.cfg_err),  int'(x.err));
                if (win) begin
                    win_ticks += int'(bus.div_tick);
                    win_imps  += int'(bus.imp);
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        bus.en = 1'b0;
        bus.div_load = 1'b0;
        bus.div_val = '0;
        bus.pulse_val = '0;
        m_reset();
        #7 check_reset_outputs("por");
        @(negedge clk);
        reset = 1'b1;

        // Default ratio 6, pulse period 5 over 24 enabled cycles
        win = 1;
        run(24, 1'b1);
        #4;
        win = 0;
        check("win_ticks", win_ticks, 4);
        check("win_imps",  win_imps,  4);

        // Load 5/3 at counter=1; applied on the next wrap
        step(1'b1, 1'b0, 0, 0);
        step(1'b1, 1'b1, 5, 3);
        run(16, 1'b1);

        // Rejected loads, then a valid one
        async_reset();
        run(2, 1'b1);
        step(1'b1, 1'b1, 1, 3);
        run(3, 1'b1);
        step(1'b1, 1'b1, 4, 0);
        run(2, 1'b1);
        step(1'b1, 1'b1, 4, 2);
        run(14, 1'b1);

        // Second load while busy is ignored
        step(1'b1, 1'b1, 7, 2);
        step(1'b1, 1'b1, 9, 4);
        step(1'b1, 1'b1, 1, 0);
        run(20, 1'b1);

        // Pending load frozen by en=0, pulse period 1
        run(2, 1'b1);
        step(1'b1, 1'b1, 3, 1);
        run(7, 1'b0);
        run(12, 1'b1);

        // Async reset with a load pending discards it
        step(1'b1, 1'b1, 8, 4);
        step(1'b1, 1'b0, 0, 0);
        async_reset();
        run(14, 1'b1);

        // Maximum ratio and pulse period
        step(1'b1, 1'b1, 255, 255);
        run(530, 1'b1);

        // Random enable and configuration traffic
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 9) < 8), ($urandom_range(0, 5) == 0),
                 int'($urandom_range(0, 12)), int'($urandom_range(0, 6)));
        end

        #4;
        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
